// File: rtl/rx_deskew_ctrl_pkg.sv
// Shared types for the RX deskew sequencer: FSM state encoding and AM-check result codes.
// Reused by the lane merger and the debug status register.
package rx_deskew_ctrl_pkg;

    typedef enum logic [1:0] {
        StRst  = 2'd0,
        StFill = 2'd1,
        StRead = 2'd2,
        StLock = 2'd3
    } dsk_state_e;

    typedef enum logic [1:0] {
        AmNone    = 2'd0,
        AmAligned = 2'd1,
        AmMixed   = 2'd2,
        AmPartial = 2'd3
    } am_chk_e;

    localparam int unsigned MaxLanes  = 32;
    localparam logic [7:0]  ErrCntMax = 8'hFF;

    // Classify one read cycle across the enabled lanes; callers zero-extend to MaxLanes.
    function automatic am_chk_e am_check(input logic [MaxLanes-1:0] valid,
                                         input logic [MaxLanes-1:0] isam,
                                         input logic [MaxLanes-1:0] mask);
        am_chk_e res;
        res = AmNone;
        if (mask != '0) begin
            if ((valid & mask) == mask) begin
                if ((isam & mask) == mask) begin
                    res = AmAligned;
                end else if ((isam & mask) != '0) begin
                    res = AmMixed;
                end
            end else if ((valid & mask) != '0) begin
                res = AmPartial;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/rx_deskew_ctrl_if.sv
// Lane-buffer control bundle between the deskew sequencer (master) and the lane side (slave).
interface rx_deskew_ctrl_if #(
    parameter int unsigned LANES     = 4,
    parameter int unsigned ADD_WIDTH = 4
);
    logic                 i_u_restart;
    logic [ADD_WIDTH-1:0] i_u_cfg_thres;
    logic [LANES-1:0]     i_u_lden;
    logic [LANES-1:0]     i_u_half_full;
    logic [LANES-1:0]     i_u_flow;
    logic [LANES-1:0]     i_u_rd_valid;
    logic [LANES-1:0]     i_u_rd_isam;
    logic                 o_u_unif_rst_n;
    logic [ADD_WIDTH-1:0] o_u_half_thres;
    logic                 o_u_rd_en;
    logic                 o_u_deskew_ok;
    logic [1:0]           o_u_state;
    logic [7:0]           o_u_err_cnt;

    modport master (
        input  i_u_restart, i_u_cfg_thres, i_u_lden, i_u_half_full, i_u_flow,
               i_u_rd_valid, i_u_rd_isam,
        output o_u_unif_rst_n, o_u_half_thres, o_u_rd_en, o_u_deskew_ok, o_u_state,
               o_u_err_cnt
    );

    modport slave (
        output i_u_restart, i_u_cfg_thres, i_u_lden, i_u_half_full, i_u_flow,
               i_u_rd_valid, i_u_rd_isam,
        input  o_u_unif_rst_n, o_u_half_thres, o_u_rd_en, o_u_deskew_ok, o_u_state,
               o_u_err_cnt
    );
endinterface

// File: rtl/rx_deskew_ctrl.sv
// Uniform-clock sequencer for the per-lane RX deskew buffers: common reset, fill wait,
// common read enable and AM alignment check, with re-reset on any fault.
module rx_deskew_ctrl
    import rx_deskew_ctrl_pkg::*;
#(
    parameter int unsigned LANES     = 4,
    parameter int unsigned ADD_WIDTH = 4,
    parameter int unsigned RST_CYC   = 8,
    parameter int unsigned TMO_W     = 16
) (
    input  logic              i_uniform_clk,
    input  logic              i_u_rst_n,
    rx_deskew_ctrl_if.master  bus
);

    localparam int unsigned        RstCntW = $clog2(RST_CYC);
    localparam logic [RstCntW-1:0] RstLast = RstCntW'(RST_CYC - 1);
    // Last count before the timeout counter would reach all-ones.
    localparam logic [TMO_W-1:0]   TmoLast = ~TMO_W'(1);

    dsk_state_e           state_q, state_d;
    logic [RstCntW-1:0]   rst_cnt_q, rst_cnt_d;
    logic [TMO_W-1:0]     tmo_cnt_q, tmo_cnt_d;
    logic [LANES-1:0]     mask_q, mask_d;
    logic [ADD_WIDTH-1:0] thres_q, thres_d;
    logic [7:0]           err_cnt_q, err_cnt_d;
    logic                 rd_en_q, rd_en_d;
    logic                 unif_rst_n_q, deskew_ok_q;

    logic [MaxLanes-1:0]  valid_ext, isam_ext, mask_ext;
    am_chk_e              am_res;
    logic                 active, in_rd, fault, enter_rst;

    always_comb begin
        valid_ext = '0;
        isam_ext  = '0;
        mask_ext  = '0;
        valid_ext[LANES-1:0] = bus.i_u_rd_valid;
        isam_ext[LANES-1:0]  = bus.i_u_rd_isam;
        mask_ext[LANES-1:0]  = mask_q;
    end

    always_comb begin
        am_res    = am_check(valid_ext, isam_ext, mask_ext);
        active    = (state_q != StRst);
        in_rd     = (state_q == StRead) || (state_q == StLock);
        fault     = active && (((bus.i_u_flow & mask_q) != '0)
                    || (in_rd && ((am_res == AmMixed) || (am_res == AmPartial)))
                    || (((state_q == StFill) && (mask_q != '0)) || (state_q == StRead))
                       && (tmo_cnt_q == TmoLast));
        enter_rst = fault || bus.i_u_restart || (active && (bus.i_u_lden != mask_q));

        state_d   = state_q;
        rst_cnt_d = rst_cnt_q;
        tmo_cnt_d = tmo_cnt_q;
        mask_d    = mask_q;
        thres_d   = thres_q;
        err_cnt_d = err_cnt_q;

        if (fault && (err_cnt_q != ErrCntMax)) begin
            err_cnt_d = err_cnt_q + 8'd1;
        end
        // Reload the threshold when a pass starts, including the first pass after reset.
        if (enter_rst || ((state_q == StRst) && (rst_cnt_q == '0))) begin
            thres_d = bus.i_u_cfg_thres;
        end

        if (enter_rst) begin
            state_d   = StRst;
            rst_cnt_d = '0;
        end else begin
            unique case (state_q)
                StRst: begin
                    if (rst_cnt_q == RstLast) begin
                        state_d   = StFill;
                        mask_d    = bus.i_u_lden;
                        tmo_cnt_d = '0;
                    end else begin
                        rst_cnt_d = rst_cnt_q + RstCntW'(1);
                    end
                end
                StFill: begin
                    if (mask_q != '0) begin
                        tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
                        if ((bus.i_u_half_full & mask_q) == mask_q) begin
                            state_d   = StRead;
                            tmo_cnt_d = '0;
                        end
                    end
                end
                StRead: begin
                    tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
                    if (am_res == AmAligned) begin
                        state_d = StLock;
                    end
                end
                StLock: begin
                end
                default: begin
                end
            endcase
        end

        if ((state_q == StFill) && (state_d == StRead)) begin
            rd_en_d = 1'b1;
        end else if ((state_d == StRead) || (state_d == StLock)) begin
            rd_en_d = ~rd_en_q;
        end else begin
            rd_en_d = 1'b0;
        end
    end

    always_ff @(posedge i_uniform_clk or negedge i_u_rst_n) begin
        if (!i_u_rst_n) begin
            state_q      <= StRst;
            rst_cnt_q    <= '0;
            tmo_cnt_q    <= '0;
            mask_q       <= '0;
            thres_q      <= '0;
            err_cnt_q    <= '0;
            rd_en_q      <= 1'b0;
            unif_rst_n_q <= 1'b0;
            deskew_ok_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            rst_cnt_q    <= rst_cnt_d;
            tmo_cnt_q    <= tmo_cnt_d;
            mask_q       <= mask_d;
            thres_q      <= thres_d;
            err_cnt_q    <= err_cnt_d;
            rd_en_q      <= rd_en_d;
            unif_rst_n_q <= (state_d != StRst);
            deskew_ok_q  <= (state_d == StLock);
        end
    end

    assign bus.o_u_unif_rst_n = unif_rst_n_q;
    assign bus.o_u_half_thres = thres_q;
    assign bus.o_u_rd_en      = rd_en_q;
    assign bus.o_u_deskew_ok  = deskew_ok_q;
    assign bus.o_u_state      = state_q;
    assign bus.o_u_err_cnt    = err_cnt_q;

endmodule

// File: tb/tb_rx_deskew_ctrl.sv
// Directed bench for rx_deskew_ctrl: expectations queued with each stimulus step and
// compared one cycle later; a second instance with a short timeout covers saturation.
module tb_rx_deskew_ctrl;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    rx_deskew_ctrl_if #(.LANES(4), .ADD_WIDTH(4)) bus ();
    rx_deskew_ctrl_if #(.LANES(4), .ADD_WIDTH(4)) tbus ();

    rx_deskew_ctrl #(.LANES(4), .ADD_WIDTH(4), .RST_CYC(8), .TMO_W(16)) dut (
        .i_uniform_clk(clk),
        .i_u_rst_n    (rst_n),
        .bus          (bus)
    );

    rx_deskew_ctrl #(.LANES(4), .ADD_WIDTH(4), .RST_CYC(8), .TMO_W(4)) dut_t (
        .i_uniform_clk(clk),
        .i_u_rst_n    (rst_n),
        .bus          (tbus)
    );

    typedef enum int {SState, SRdEn, SOk, SUrst, SErr, SThres, STState, STErr, STRdEn, STUrst} sel_e;
    typedef struct {
        string       tag;
        sel_e        sel;
        logic [31:0] exp;
    } exp_t;

    exp_t sb_q[$];

    function automatic logic [31:0] obs(input sel_e s);
        case (s)
            SState:  return 32'(bus.o_u_state);
            SRdEn:   return 32'(bus.o_u_rd_en);
            SOk:     return 32'(bus.o_u_deskew_ok);
            SUrst:   return 32'(bus.o_u_unif_rst_n);
            SErr:    return 32'(bus.o_u_err_cnt);
            SThres:  return 32'(bus.o_u_half_thres);
            STState: return 32'(tbus.o_u_state);
            STErr:   return 32'(tbus.o_u_err_cnt);
            STRdEn:  return 32'(tbus.o_u_rd_en);
            STUrst:  return 32'(tbus.o_u_unif_rst_n);
            default: return 32'hDEAD_BEEF;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] o, input logic [31:0] e);
        checks++;
        assert (o === e) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
        end
    endtask

    task automatic exp_nxt(input string tag, input sel_e s, input logic [31:0] v);
        exp_t x;
        x.tag = tag;
        x.sel = s;
        x.exp = v;
        sb_q.push_back(x);
    endtask

    // Advance one cycle, then retire every expectation queued for this cycle.
    task automatic tick();
        exp_t x;
        @(posedge clk);
        #1;
        while (sb_q.size() > 0) begin
            x = sb_q.pop_front();
            check(x.tag, obs(x.sel), x.exp);
        end
    endtask

    task automatic fill_to_read(input logic [3:0] m, input string tag);
        int n;
        n = 0;
        bus.i_u_half_full = '0;
        while ((bus.o_u_state != 2'd1) && (n < 40)) begin
            tick();
            n++;
        end
        check({tag, "_reach_fill"}, obs(SState), 32'd1);
        bus.i_u_half_full = m;
        exp_nxt({tag, "_read_state"}, SState, 32'd2);
        exp_nxt({tag, "_rd_en_first"}, SRdEn, 32'd1);
        tick();
    endtask

    task automatic lock_up(input logic [3:0] m, input string tag);
        fill_to_read(m, tag);
        exp_nxt({tag, "_rd_en_low"}, SRdEn, 32'd0);
        tick();
        bus.i_u_rd_valid = 4'hF;
        bus.i_u_rd_isam  = 4'hF;
        exp_nxt({tag, "_lock_state"}, SState, 32'd3);
        exp_nxt({tag, "_lock_ok"}, SOk, 32'd1);
        tick();
        bus.i_u_rd_valid = '0;
        bus.i_u_rd_isam  = '0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        bus.i_u_restart    = 1'b0;
        bus.i_u_cfg_thres  = 4'h6;
        bus.i_u_lden       = 4'hF;
        bus.i_u_half_full  = '0;
        bus.i_u_flow       = '0;
        bus.i_u_rd_valid   = '0;
        bus.i_u_rd_isam    = '0;
        tbus.i_u_restart   = 1'b0;
        tbus.i_u_cfg_thres = 4'h3;
        tbus.i_u_lden      = 4'h0;
        tbus.i_u_half_full = 4'hF;
        tbus.i_u_flow      = '0;
        tbus.i_u_rd_valid  = '0;
        tbus.i_u_rd_isam   = '0;

        #22;
        check("rst_state", obs(SState), 32'd0);
        check("rst_unif_rst_n", obs(SUrst), 32'd0);
        check("rst_rd_en", obs(SRdEn), 32'd0);
        check("rst_deskew_ok", obs(SOk), 32'd0);
        check("rst_err_cnt", obs(SErr), 32'd0);
        check("rst_half_thres", obs(SThres), 32'd0);

        // T1: staggered half_full; release puts the block in cycle 0 of its reset pass.
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 1; c <= 36; c++) begin
            bus.i_u_half_full = {(c - 1) >= 30, (c - 1) >= 25, (c - 1) >= 22, (c - 1) >= 20};
            exp_nxt("t1_rd_en", SRdEn, (c >= 31) ? 32'((c - 31) % 2 == 0) : 32'd0);
            exp_nxt("t1_unif_rst_n", SUrst, 32'(c >= 8));
            if (c == 8) exp_nxt("t1_half_thres", SThres, 32'h6);
            if (c >= 31) exp_nxt("t1_state", SState, 32'd2);
            tick();
        end

        // T2: aligned AM on all lanes.
        bus.i_u_rd_valid = 4'hF;
        bus.i_u_rd_isam  = 4'hF;
        exp_nxt("t2_state", SState, 32'd3);
        exp_nxt("t2_deskew_ok", SOk, 32'd1);
        exp_nxt("t2_err_cnt", SErr, 32'd0);
        exp_nxt("t2_rd_en", SRdEn, 32'd1);
        tick();
        bus.i_u_rd_valid = '0;
        bus.i_u_rd_isam  = '0;
        exp_nxt("t2_rd_en_toggle", SRdEn, 32'd0);
        exp_nxt("t2_deskew_hold", SOk, 32'd1);
        tick();

        // T3: mixed AM in LOCK, new threshold taken at the re-reset.
        bus.i_u_cfg_thres = 4'h9;
        bus.i_u_half_full = '0;
        bus.i_u_rd_valid  = 4'hF;
        bus.i_u_rd_isam   = 4'b0111;
        exp_nxt("t3_state", SState, 32'd0);
        exp_nxt("t3_deskew_ok", SOk, 32'd0);
        exp_nxt("t3_unif_rst_n", SUrst, 32'd0);
        exp_nxt("t3_err_cnt", SErr, 32'd1);
        exp_nxt("t3_rd_en", SRdEn, 32'd0);
        exp_nxt("t3_half_thres", SThres, 32'h9);
        tick();
        bus.i_u_rd_valid = '0;
        bus.i_u_rd_isam  = '0;
        repeat (7) begin
            exp_nxt("t3_rst_hold", SUrst, 32'd0);
            tick();
        end
        exp_nxt("t3_rst_release", SUrst, 32'd1);
        exp_nxt("t3_fill", SState, 32'd1);
        tick();

        // T4: masked-off flow ignored, enabled-lane flow faults; mask change is not a fault.
        bus.i_u_lden = 4'hB;
        exp_nxt("t4_mask_chg_state", SState, 32'd0);
        exp_nxt("t4_mask_chg_err", SErr, 32'd1);
        tick();
        lock_up(4'hB, "t4b");
        bus.i_u_flow = 4'b0100;
        exp_nxt("t4_flow_masked_state", SState, 32'd3);
        exp_nxt("t4_flow_masked_err", SErr, 32'd1);
        tick();
        bus.i_u_flow = '0;
        bus.i_u_lden = 4'hF;
        exp_nxt("t4_mask_back_state", SState, 32'd0);
        exp_nxt("t4_mask_back_err", SErr, 32'd1);
        tick();
        lock_up(4'hF, "t4f");
        bus.i_u_flow = 4'b0100;
        exp_nxt("t4_flow_state", SState, 32'd0);
        exp_nxt("t4_flow_err", SErr, 32'd2);
        exp_nxt("t4_flow_unif_rst_n", SUrst, 32'd0);
        tick();
        bus.i_u_flow = '0;

        // T6a: restart in READ, then restart inside RST restarts the count.
        fill_to_read(4'hF, "t6r");
        bus.i_u_restart = 1'b1;
        bus.i_u_half_full = '0;
        exp_nxt("t6_restart_state", SState, 32'd0);
        exp_nxt("t6_restart_err", SErr, 32'd2);
        exp_nxt("t6_restart_rd_en", SRdEn, 32'd0);
        tick();
        bus.i_u_restart = 1'b0;
        repeat (3) tick();
        bus.i_u_restart = 1'b1;
        exp_nxt("t6_rerestart_state", SState, 32'd0);
        tick();
        bus.i_u_restart = 1'b0;
        repeat (7) begin
            exp_nxt("t6_rst_count", SState, 32'd0);
            tick();
        end
        exp_nxt("t6_rst_done", SState, 32'd1);
        tick();

        // Zero mask: no read and no timeout even with half_full high.
        check("zero_mask_state", obs(STState), 32'd1);
        check("zero_mask_rd_en", obs(STRdEn), 32'd0);
        check("zero_mask_err", obs(STErr), 32'd0);
        check("zero_mask_unif_rst_n", obs(STUrst), 32'd1);

        // T5: fill timeout with TMO_W=4 and saturation of the fault counter.
        tbus.i_u_half_full = '0;
        tbus.i_u_lden      = 4'hF;
        exp_nxt("t5_mask_chg_state", STState, 32'd0);
        exp_nxt("t5_mask_chg_err", STErr, 32'd0);
        tick();
        repeat (7) begin
            exp_nxt("t5_rst", STState, 32'd0);
            tick();
        end
        for (int k = 1; k <= 15; k++) begin
            exp_nxt("t5_fill", STState, 32'd1);
            tick();
        end
        exp_nxt("t5_tmo_state", STState, 32'd0);
        exp_nxt("t5_tmo_err", STErr, 32'd1);
        tick();
        for (int i = 2; i <= 300; i++) begin
            repeat (22) tick();
            exp_nxt("t5_pass_state", STState, 32'd0);
            exp_nxt("t5_pass_err", STErr, (i > 255) ? 32'd255 : 32'(i));
            tick();
        end

        // T6b: async reset while locked, observed before any clock edge.
        lock_up(4'hF, "t6l");
        check("t6_pre_rd_en", obs(SRdEn), 32'd1);
        rst_n = 1'b0;
        #1;
        check("t6_async_state", obs(SState), 32'd0);
        check("t6_async_unif_rst_n", obs(SUrst), 32'd0);
        check("t6_async_rd_en", obs(SRdEn), 32'd0);
        check("t6_async_deskew_ok", obs(SOk), 32'd0);
        check("t6_async_err", obs(SErr), 32'd0);
        check("t6_async_thres", obs(SThres), 32'd0);
        check("t6_async_t_err", obs(STErr), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
